load_store_unit: RTL

Initiator side of the data-memory port: accepts one load/store request from the control FSM, computes the byte effective address, drives the word-addressed data memory through a req/ack handshake, and returns extended load data or a fault. The data memory has no byte enables, so sub-word stores are done as read-modify-write. Sits between the register file/immediate path and the data memory.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 encodings,
// default memory depth and small decode helpers.
package lsu_pkg;

  // Default word-index width of the data memory (32 words).
  localparam int LSU_AW = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_RD,
    ST_WR,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know sb/sh/sw; loads additionally have the unsigned variants.
  function automatic logic f3Legal(input logic isWrite, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (isWrite) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic f3Misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU)) begin
      bad = lo[0];
    end else if (f3 == F3_W) begin
      bad = (lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends load data from
// a memory word, and merges sub-word store data into a memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    byteLane = word_i[7:0];
    case (byte_off_i)
      2'd0:    byteLane = word_i[7:0];
      2'd1:    byteLane = word_i[15:8];
      2'd2:    byteLane = word_i[23:16];
      default: byteLane = word_i[31:24];
    endcase
    halfLane = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load type.
  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byteLane[7]}}, byteLane};
      F3_H:    load_o = {{16{halfLane[15]}}, halfLane};
      F3_BU:   load_o = {24'd0, byteLane};
      F3_HU:   load_o = {16'd0, halfLane};
      default: load_o = word_i;
    endcase
  end

  // Overwrite only the addressed lane with store data; other bytes keep their value.
  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (byte_off_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (byte_off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else               merged_o[15:0]  = wdata_i[15:0];
      end
      F3_W:    merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time, forms the byte address,
// talks to a word-addressed memory via req/ack, and performs sub-word stores
// as read-modify-write because the memory has no byte enables.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = LSU_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [2:0]    funct3_i,
  input  logic [31:0]   base_i,
  input  logic [11:0]   immediate_i,
  input  logic [31:0]   wdata_i,
  output logic          resp_valid_o,
  output logic [31:0]   resp_data_o,
  output logic          resp_fault_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_ack_i
);

  lsu_state_e  state_q, state_d;

  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] base_q;
  logic [11:0] imm_q;
  logic [31:0] wdata_q;
  logic [31:0] eaddr_q;
  logic [31:0] memWdata_q;
  logic [31:0] respData_q;
  logic        respFault_q;

  logic [31:0] eaddrCalc;
  logic        calcFault;
  logic [31:0] loadValue;
  logic [31:0] mergedWord;

  // Effective address and fault decision, evaluated while in CALC.
  always_comb begin
    eaddrCalc = base_q + {{20{imm_q[11]}}, imm_q};
    calcFault = !f3Legal(write_q, funct3_q) ||
                f3Misaligned(funct3_q, eaddrCalc[1:0]) ||
                (eaddrCalc[31:AW+2] != '0);
  end

  lsu_align u_align (
    .word_i     (mem_rdata_i),
    .byte_off_i (eaddr_q[1:0]),
    .funct3_i   (funct3_q),
    .wdata_i    (wdata_q),
    .load_o     (loadValue),
    .merged_o   (mergedWord)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and strobe/handshake outputs.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_CALC;
      end
      ST_CALC: begin
        if (calcFault)                          state_d = ST_DONE;
        else if (write_q && funct3_q == F3_W)   state_d = ST_WR;
        else                                    state_d = ST_RD;
      end
      ST_RD: begin
        mem_read_o = 1'b1;
        if (mem_ack_i) state_d = write_q ? ST_WR : ST_DONE;
      end
      ST_WR: begin
        mem_write_o = 1'b1;
        if (mem_ack_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request fields when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      base_q   <= 32'd0;
      imm_q    <= 12'd0;
      wdata_q  <= 32'd0;
    end else if (state_q == ST_IDLE && req_valid_i) begin
      write_q  <= req_write_i;
      funct3_q <= funct3_i;
      base_q   <= base_i;
      imm_q    <= immediate_i;
      wdata_q  <= wdata_i;
    end
  end

  // Register the effective address; it also supplies the memory word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 eaddr_q <= 32'd0;
    else if (state_q == ST_CALC) eaddr_q <= eaddrCalc;
  end

  // Store word: raw data for sw, or the merged word after the read of sb/sh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memWdata_q <= 32'd0;
    end else if (state_q == ST_CALC && !calcFault && write_q && funct3_q == F3_W) begin
      memWdata_q <= wdata_q;
    end else if (state_q == ST_RD && mem_ack_i && write_q) begin
      memWdata_q <= mergedWord;
    end
  end

  // Response payload, updated on the transition into DONE and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respData_q  <= 32'd0;
      respFault_q <= 1'b0;
    end else begin
      if (state_q == ST_CALC && calcFault) begin
        respData_q  <= eaddrCalc;
        respFault_q <= 1'b1;
      end else if (state_q == ST_RD && mem_ack_i && !write_q) begin
        respData_q  <= loadValue;
        respFault_q <= 1'b0;
      end else if (state_q == ST_WR && mem_ack_i) begin
        respData_q  <= eaddr_q;
        respFault_q <= 1'b0;
      end
    end
  end

  assign mem_addr_o   = eaddr_q[AW+1:2];
  assign mem_wdata_o  = memWdata_q;
  assign resp_data_o  = respData_q;
  assign resp_fault_o = respFault_q;

endmodule
